mem_stage_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/mem_stage_ctrl_memwb_latch.sv | 62 ++++++
 rtl/mem_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the memory stage: word/register types, the MEM FSM
// encoding and the bit layout of the MEM/WB control flags.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;
  localparam int REG_BITS  = 5;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [REG_BITS-1:0]  regbits_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } mem_state_t;

  // Control flags carried through the MEM/WB latch, one bit each.
  localparam int CTRL_W        = 5;
  localparam int CTRL_REGWEN   = 0;
  localparam int CTRL_PC2REG   = 1;
  localparam int CTRL_MEM2REG  = 2;
  localparam int CTRL_HALT     = 3;
  localparam int CTRL_MISALIGN = 4;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return |addr_lo;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_memwb_latch.sv
// MEM/WB latch: data fields load on retire and hold otherwise; control flags
// load on retire and otherwise take the caller-supplied bubble value.
module memwb_latch
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = WORD_BITS,
  parameter int REG_W  = REG_BITS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [WORD_W-1:0] npc_d,
  input  logic [WORD_W-1:0] rdat_d,
  input  logic [WORD_W-1:0] result_d,
  input  logic [REG_W-1:0]  regdest_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [CTRL_W-1:0] ctrl_bubble,
  output logic [WORD_W-1:0] npc_q,
  output logic [WORD_W-1:0] rdat_q,
  output logic [WORD_W-1:0] result_q,
  output logic [REG_W-1:0]  regdest_q,
  output logic [CTRL_W-1:0] ctrl_q
);

  logic [WORD_W-1:0] npc_reg;
  logic [WORD_W-1:0] rdat_reg;
  logic [WORD_W-1:0] result_reg;
  logic [REG_W-1:0]  regdest_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      npc_reg     <= '0;
      rdat_reg    <= '0;
      result_reg  <= '0;
      regdest_reg <= '0;
    end else if (load) begin
      npc_reg     <= npc_d;
      rdat_reg    <= rdat_d;
      result_reg  <= result_d;
      regdest_reg <= regdest_d;
    end
  end

  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl
    logic bit_reg;
    always_ff @(posedge CLK) begin
      if (RST)
        bit_reg <= 1'b0;
      else if (load)
        bit_reg <= ctrl_d[gi];
      else
        bit_reg <= ctrl_bubble[gi];
    end
    assign ctrl_q[gi] = bit_reg;
  end

  assign npc_q     = npc_reg;
  assign rdat_q    = rdat_reg;
  assign result_q  = result_reg;
  assign regdest_q = regdest_reg;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data-cache requests from the EX/MEM latch,
// stalls upstream until dhit, and feeds the MEM/WB latch; freezes after halt.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              exmem_valid,
  input  logic [WORD_W-1:0] exmem_npc,
  input  logic [WORD_W-1:0] exmem_result,
  input  logic [WORD_W-1:0] exmem_store,
  input  logic [REG_W-1:0]  exmem_regdest,
  input  logic              exmem_regwen,
  input  logic              exmem_pc2reg,
  input  logic              exmem_mem2reg,
  input  logic              exmem_memren,
  input  logic              exmem_memwen,
  input  logic              exmem_halt,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              mem_stall,
  output logic [WORD_W-1:0] MEM_npc_OUT,
  output logic [WORD_W-1:0] MEM_rdat_OUT,
  output logic [WORD_W-1:0] MEM_result_OUT,
  output logic [REG_W-1:0]  MEM_RegDest_OUT,
  output logic              MEM_RegWen_OUT,
  output logic              MEM_pc2reg_OUT,
  output logic              MEM_mem2reg_OUT,
  output logic              MEM_halt_OUT,
  output logic              misalign
);

  mem_state_t state_reg, state_next;

  logic              mem_op;
  logic              is_load;
  logic              retire;
  logic [WORD_W-1:0] rdat_next;
  logic [CTRL_W-1:0] ctrl_next;
  logic [CTRL_W-1:0] ctrl_bubble;
  logic [CTRL_W-1:0] ctrl_q;

  assign mem_op  = exmem_valid & (exmem_memren | exmem_memwen);
  // A simultaneous read+write is treated as a store only.
  assign is_load = exmem_memren & ~exmem_memwen;

  always_ff @(posedge CLK) begin
    if (RST)
      state_reg <= RUN;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    mem_stall  = 1'b0;
    retire     = 1'b0;
    dmemaddr   = {exmem_result[WORD_W-1:2], 2'b00};
    dmemstore  = exmem_store;
    case (state_reg)
      RUN: begin
        dmemWEN   = exmem_valid & exmem_memwen;
        dmemREN   = exmem_valid & is_load;
        mem_stall = mem_op & ~dhit;
        retire    = exmem_valid & ~(mem_op & ~dhit);
        if (exmem_valid & ~(mem_op & ~dhit) & exmem_halt)
          state_next = HALTED;
      end
      HALTED: state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  assign rdat_next = is_load ? dmemload : '0;

  always_comb begin
    ctrl_next                = '0;
    ctrl_next[CTRL_REGWEN]   = exmem_regwen;
    ctrl_next[CTRL_PC2REG]   = exmem_pc2reg;
    ctrl_next[CTRL_MEM2REG]  = exmem_mem2reg;
    ctrl_next[CTRL_HALT]     = exmem_halt;
    ctrl_next[CTRL_MISALIGN] = mem_op & is_misaligned(exmem_result[1:0]);
  end

  // Bubbles clear every flag except halt, which stays set once halted.
  always_comb begin
    ctrl_bubble            = '0;
    ctrl_bubble[CTRL_HALT] = (state_reg == HALTED);
  end

  memwb_latch #(
    .WORD_W (WORD_W),
    .REG_W  (REG_W)
  ) u_memwb_latch (
    .CLK         (CLK),
    .RST         (RST),
    .load        (retire),
    .npc_d       (exmem_npc),
    .rdat_d      (rdat_next),
    .result_d    (exmem_result),
    .regdest_d   (exmem_regdest),
    .ctrl_d      (ctrl_next),
    .ctrl_bubble (ctrl_bubble),
    .npc_q       (MEM_npc_OUT),
    .rdat_q      (MEM_rdat_OUT),
    .result_q    (MEM_result_OUT),
    .regdest_q   (MEM_RegDest_OUT),
    .ctrl_q      (ctrl_q)
  );

  assign MEM_RegWen_OUT  = ctrl_q[CTRL_REGWEN];
  assign MEM_pc2reg_OUT  = ctrl_q[CTRL_PC2REG];
  assign MEM_mem2reg_OUT = ctrl_q[CTRL_MEM2REG];
  assign MEM_halt_OUT    = ctrl_q[CTRL_HALT];
  assign misalign        = ctrl_q[CTRL_MISALIGN];

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: each instruction is applied as a transaction with a
// chosen miss latency and checked against an instruction-level writeback model.
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        exmem_valid;
  logic [31:0] exmem_npc, exmem_result, exmem_store;
  logic [4:0]  exmem_regdest;
  logic        exmem_regwen, exmem_pc2reg, exmem_mem2reg;
  logic        exmem_memren, exmem_memwen, exmem_halt;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        mem_stall;
  logic [31:0] MEM_npc_OUT, MEM_rdat_OUT, MEM_result_OUT;
  logic [4:0]  MEM_RegDest_OUT;
  logic        MEM_RegWen_OUT, MEM_pc2reg_OUT, MEM_mem2reg_OUT, MEM_halt_OUT;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  // Writeback model: last retired instruction's data and whether a halt retired.
  bit          m_halted;
  logic [31:0] m_npc, m_rdat, m_result;
  logic [4:0]  m_rd;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .exmem_valid(exmem_valid), .exmem_npc(exmem_npc), .exmem_result(exmem_result),
    .exmem_store(exmem_store), .exmem_regdest(exmem_regdest),
    .exmem_regwen(exmem_regwen), .exmem_pc2reg(exmem_pc2reg), .exmem_mem2reg(exmem_mem2reg),
    .exmem_memren(exmem_memren), .exmem_memwen(exmem_memwen), .exmem_halt(exmem_halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .mem_stall(mem_stall),
    .MEM_npc_OUT(MEM_npc_OUT), .MEM_rdat_OUT(MEM_rdat_OUT), .MEM_result_OUT(MEM_result_OUT),
    .MEM_RegDest_OUT(MEM_RegDest_OUT), .MEM_RegWen_OUT(MEM_RegWen_OUT),
    .MEM_pc2reg_OUT(MEM_pc2reg_OUT), .MEM_mem2reg_OUT(MEM_mem2reg_OUT),
    .MEM_halt_OUT(MEM_halt_OUT), .misalign(misalign)
  );

  wire [66:0]  got_c  = {dmemREN, dmemWEN, mem_stall, dmemaddr, dmemstore};
  wire [105:0] got_wb = {MEM_npc_OUT, MEM_rdat_OUT, MEM_result_OUT, MEM_RegDest_OUT,
                         MEM_RegWen_OUT, MEM_pc2reg_OUT, MEM_mem2reg_OUT, MEM_halt_OUT, misalign};

  task automatic clear_inputs();
    exmem_valid = 0; exmem_npc = 0; exmem_result = 0; exmem_store = 0; exmem_regdest = 0;
    exmem_regwen = 0; exmem_pc2reg = 0; exmem_mem2reg = 0;
    exmem_memren = 0; exmem_memwen = 0; exmem_halt = 0; dhit = 0; dmemload = 0;
  endtask

  task automatic model_reset();
    m_halted = 0; m_npc = 0; m_rdat = 0; m_result = 0; m_rd = 0;
  endtask

  // One instruction held on EX/MEM until the cache answers after 'lat' miss cycles.
  task automatic run_txn(input string name, input bit v, input bit ren, input bit wen,
                         input bit hlt, input bit rwen, input bit p2r, input bit m2r,
                         input logic [31:0] res, input logic [31:0] st, input logic [31:0] npc,
                         input logic [31:0] ld, input logic [4:0] rd, input int lat);
    bit memop;
    int n;
    logic [66:0]  exp_c;
    logic [105:0] exp_wb;
    memop = v && (ren || wen) && !m_halted;
    n = memop ? lat : 0;
    exmem_valid = v; exmem_memren = ren; exmem_memwen = wen; exmem_halt = hlt;
    exmem_regwen = rwen; exmem_pc2reg = p2r; exmem_mem2reg = m2r;
    exmem_result = res; exmem_store = st; exmem_npc = npc; exmem_regdest = rd;
    for (int c = 0; c <= n; c++) begin
      dhit = memop ? (c == n) : 1'($urandom_range(0, 1));
      dmemload = (c == n) ? ld : $urandom;
      #1;
      exp_c = {!m_halted && v && ren && !wen, !m_halted && v && wen, memop && (c < n),
               res & 32'hFFFF_FFFC, st};
      tests++;
      if (got_c !== exp_c) begin
        fails++;
        $display("FAIL %s cyc%0d cache/stall got=%h expected=%h", name, c, got_c, exp_c);
      end
      @(posedge CLK); #1;
      if (c < n || !v || m_halted) begin
        exp_wb = {m_npc, m_rdat, m_result, m_rd, 4'b0000, m_halted, 1'b0};
        exp_wb[1] = m_halted;
        exp_wb[5:2] = 4'b0000;
        exp_wb = {m_npc, m_rdat, m_result, m_rd, 3'b000, m_halted, 1'b0};
      end else begin
        m_npc = npc; m_result = res; m_rd = rd;
        m_rdat = (ren && !wen) ? ld : 32'h0;
        exp_wb = {m_npc, m_rdat, m_result, m_rd, rwen, p2r, m2r, hlt,
                  (ren || wen) && (res[1:0] != 2'b00)};
        if (hlt) m_halted = 1;
      end
      tests++;
      if (got_wb !== exp_wb) begin
        fails++;
        $display("FAIL %s cyc%0d writeback got=%h expected=%h", name, c, got_wb, exp_wb);
      end
    end
    $display("[TB] txn %s v=%0d ren=%0d wen=%0d halt=%0d addr=%h lat=%0d", name, v, ren, wen, hlt, res, n);
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    @(posedge CLK); #1;
    model_reset();
    tests++;
    if (got_wb !== 106'd0) begin
      fails++;
      $display("FAIL reset writeback got=%h expected=0", got_wb);
    end
    tests++;
    if (got_c !== 67'd0) begin
      fails++;
      $display("FAIL reset cache/stall got=%h expected=0", got_c);
    end
    RST = 0;
    $display("[TB] txn reset");
  endtask

  task automatic test_directed();
    run_txn("load_hit",   1, 1, 0, 0, 1, 0, 1, 32'h100, 32'h0, 32'h4, 32'hDEADBEEF, 5'd3, 0);
    run_txn("store_miss", 1, 0, 1, 0, 0, 0, 0, 32'h204, 32'hCAFE0001, 32'h8, 32'h12345678, 5'd0, 2);
    run_txn("alu",        1, 0, 0, 0, 1, 0, 0, 32'h42, 32'h0, 32'hC, 32'h0, 5'd7, 0);
    run_txn("misalign",   1, 1, 0, 0, 1, 0, 1, 32'h103, 32'h0, 32'h10, 32'hA5A5A5A5, 5'd9, 1);
    run_txn("rw_both",    1, 1, 1, 0, 1, 0, 1, 32'h302, 32'h77, 32'h14, 32'hFFFFFFFF, 5'd1, 1);
    run_txn("bubble",     0, 1, 0, 0, 1, 1, 1, 32'h400, 32'h0, 32'h18, 32'h1, 5'd2, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      run_txn("random", ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 0,
              1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
              $urandom, 5'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_miss();
    exmem_valid = 1; exmem_memren = 1; exmem_memwen = 0; exmem_result = 32'h300;
    exmem_regwen = 1; exmem_mem2reg = 1; exmem_halt = 0;
    dhit = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (mem_stall !== 1'b1) begin
        fails++;
        $display("FAIL reset_mid_miss stall cyc%0d got=%b expected=1", c, mem_stall);
      end
      if (c == 1) RST = 1;
      @(posedge CLK); #1;
    end
    model_reset();
    tests++;
    if (got_wb !== 106'd0) begin
      fails++;
      $display("FAIL reset_mid_miss writeback got=%h expected=0", got_wb);
    end
    RST = 0;
    clear_inputs();
    #1;
    tests++;
    if (got_c !== 67'd0) begin
      fails++;
      $display("FAIL reset_mid_miss cache/stall got=%h expected=0", got_c);
    end
    $display("[TB] txn reset_mid_miss");
  endtask

  task automatic test_halt();
    run_txn("halt_load",  1, 1, 0, 1, 0, 0, 0, 32'h500, 32'h0, 32'h20, 32'h0BAD0BAD, 5'd4, 2);
    run_txn("after_halt", 1, 1, 0, 0, 1, 1, 1, 32'h600, 32'h0, 32'h24, 32'h11111111, 5'd5, 2);
    run_txn("after_halt2",1, 0, 1, 0, 1, 0, 0, 32'h604, 32'h9, 32'h28, 32'h0, 5'd6, 1);
    run_txn("alu_halted", 1, 0, 0, 0, 1, 0, 0, 32'h42, 32'h0, 32'h2C, 32'h0, 5'd8, 0);
    test_reset();
    run_txn("post_reset", 1, 0, 0, 0, 1, 1, 0, 32'h99, 32'h0, 32'h30, 32'h0, 5'd10, 0);
  endtask

  initial begin
    clear_inputs();
    RST = 1;
    @(posedge CLK); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_miss();
    test_back_to_back();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
